// File: rtl/ft601_mcfifo_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module   : ft601_mcfifo_pkt_buf
// Purpose  : Multi-channel packetising write buffer for the FT601 USB path.
//            Each channel stores its word stream in a private FIFO and groups
//            the words into transfers of at most MPS_W words. A transfer is
//            closed by a full packet, an explicit push or an idle timeout. A
//            round-robin reader hands one channel's transfer at a time to the
//            downstream FT601 multi-channel FIFO master.
// Ports    : clk, reset_n (async, active low)
//            max_packet_size, flush_timeout          - static configuration
//            wr_data/wr_en/wr_push                   - per-channel write side
//            writeable/almost_unwriteable/overflow   - per-channel status
//            rd_en, rd_data, rd_valid                - read data path
//            rd_ch, rd_xfer_len, rd_xfer_req,
//            rd_xfer_almost_done, rd_xfer_done       - transfer handshake
// Revision : 1.0 - initial release
// ============================================================================
module ft601_mcfifo_pkt_buf #(
    parameter  int NUM_CH    = 4,
    parameter  int DATA_W    = 36,
    parameter  int DEPTH     = 1024,
    parameter  int TIMEOUT_W = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              max_packet_size,
    input  logic [TIMEOUT_W-1:0]     flush_timeout,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic [NUM_CH-1:0]        wr_en,
    input  logic [NUM_CH-1:0]        wr_push,
    output logic [NUM_CH-1:0]        writeable,
    output logic [NUM_CH-1:0]        almost_unwriteable,
    output logic [NUM_CH-1:0]        overflow,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [CH_W-1:0]          rd_ch,
    output logic [CNT_W-1:0]         rd_xfer_len,
    output logic                     rd_xfer_req,
    output logic                     rd_xfer_almost_done,
    output logic                     rd_xfer_done
);

    localparam int AW = CNT_W - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Packet size in words; byte-granular bits are not meaningful.
    logic [CNT_W-1:0] w_mps;
    logic [CNT_W:0]   w_mps2;
    logic             w_unused_mps;
    assign w_mps        = max_packet_size[CNT_W+1:2];
    assign w_mps2       = {w_mps, 1'b0};
    assign w_unused_mps = ^{max_packet_size[31:CNT_W+2], max_packet_size[1:0]};

    // Per-channel views shared with the reader
    logic [CNT_W-1:0]  w_cmt     [NUM_CH];
    logic [DATA_W-1:0] w_rd_word [NUM_CH];
    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_gnt;
    logic [NUM_CH-1:0] w_pop;
    logic [CNT_W-1:0]  w_gnt_len;
    logic [DATA_W-1:0] w_rd_sel;

    // Reader state
    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    // ------------------------------------------------------------------------
    // Per-channel FIFO, commit accounting and status flags
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0]    mem_q [DEPTH];
        logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
        logic [CNT_W-1:0]     free_q, free_d;
        logic [CNT_W-1:0]     unc_q, unc_d;
        logic [CNT_W-1:0]     cmt_q, cmt_d;
        logic [TIMEOUT_W-1:0] idle_q, idle_d;
        logic                 ovf_q, wrbl_q, aunw_q;
        logic                 w_store, w_timeout;
        logic [CNT_W-1:0]     w_unc_sum, w_commit_amt;

        assign w_store   = wr_en[c] && (free_q != '0);
        // Uncommitted count including a word stored on this very edge
        assign w_unc_sum = unc_q + CNT_W'(w_store);
        assign w_timeout = (flush_timeout != '0) && (unc_q != '0) &&
                           (idle_q == flush_timeout);

        // A full packet moves exactly MPS_W words; push/timeout flush the rest.
        always_comb begin
            if (w_unc_sum >= w_mps) begin
                w_commit_amt = w_mps;
            end else if (wr_push[c] || w_timeout) begin
                w_commit_amt = w_unc_sum;
            end else begin
                w_commit_amt = '0;
            end
        end

        // Commit, grant and pop may all land on one channel in one cycle.
        assign free_d = free_q - CNT_W'(w_store) + CNT_W'(w_pop[c]);
        assign unc_d  = w_unc_sum - w_commit_amt;
        assign cmt_d  = cmt_q + w_commit_amt - (w_gnt[c] ? w_gnt_len : '0);

        always_comb begin
            idle_d = idle_q;
            if (w_store || (w_commit_amt != '0)) begin
                idle_d = '0;
            end else if ((unc_q != '0) && (idle_q != {TIMEOUT_W{1'b1}})) begin
                idle_d = idle_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                free_q   <= CNT_W'(DEPTH);
                unc_q    <= '0;
                cmt_q    <= '0;
                idle_q   <= '0;
                ovf_q    <= 1'b0;
                wrbl_q   <= 1'b0;
                aunw_q   <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_q + AW'(w_store);
                rd_ptr_q <= rd_ptr_q + AW'(w_pop[c]);
                free_q   <= free_d;
                unc_q    <= unc_d;
                cmt_q    <= cmt_d;
                idle_q   <= idle_d;
                wrbl_q   <= (free_d >= w_mps);
                aunw_q   <= ({1'b0, free_d} < w_mps2);
                if (wr_en[c] && (free_q == '0)) begin
                    ovf_q <= 1'b1;
                end
            end
        end

        // Storage array carries no reset so it can map onto block RAM.
        always_ff @(posedge clk) begin
            if (w_store) begin
                mem_q[wr_ptr_q] <= wr_data[c*DATA_W +: DATA_W];
            end
        end

        assign w_rd_word[c]          = mem_q[rd_ptr_q];
        assign w_cmt[c]              = cmt_q;
        assign w_req[c]              = (cmt_q != '0);
        assign writeable[c]          = wrbl_q;
        assign almost_unwriteable[c] = aunw_q;
        assign overflow[c]           = ovf_q;
    end

    // ------------------------------------------------------------------------
    // Reader FSM: round-robin grant, pop, one-cycle done
    // ------------------------------------------------------------------------
    always_comb begin : p_fsm_comb
        logic v_found;
        v_found   = 1'b0;
        state_d   = state_q;
        ch_d      = ch_q;
        last_d    = last_q;
        len_d     = len_q;
        rem_d     = rem_q;
        w_gnt     = '0;
        w_gnt_len = '0;
        w_pop     = '0;
        unique case (state_q)
            S_IDLE: begin
                // Search order starts one past the last granted channel.
                for (int i = 1; i <= NUM_CH; i++) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (!v_found && w_req[c] &&
                            ((int'(last_q) + i == c) || (int'(last_q) + i == c + NUM_CH))) begin
                            v_found   = 1'b1;
                            w_gnt[c]  = 1'b1;
                            ch_d      = CH_W'(c);
                            last_d    = CH_W'(c);
                            w_gnt_len = (w_cmt[c] < w_mps) ? w_cmt[c] : w_mps;
                            len_d     = w_gnt_len;
                            rem_d     = w_gnt_len;
                            state_d   = S_XFER;
                        end
                    end
                end
            end
            S_XFER: begin
                if (rd_en) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (ch_q == CH_W'(c)) begin
                            w_pop[c] = 1'b1;
                        end
                    end
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CH_W'(c)) begin
                w_rd_sel = w_rd_word[c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            last_q     <= CH_W'(NUM_CH - 1);
            len_q      <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            last_q     <= last_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            rd_valid_q <= |w_pop;
            if (|w_pop) begin
                rd_data_q <= w_rd_sel;
            end
        end
    end

    assign rd_data             = rd_data_q;
    assign rd_valid            = rd_valid_q;
    assign rd_ch               = ch_q;
    assign rd_xfer_len         = len_q;
    assign rd_xfer_req         = (state_q != S_IDLE);
    assign rd_xfer_done        = (state_q == S_DONE);
    assign rd_xfer_almost_done = (state_q == S_XFER) && (rem_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: tb/tb_ft601_mcfifo_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft601_mcfifo_pkt_buf
// Purpose  : Self-checking bench for ft601_mcfifo_pkt_buf. A queue-based
//            reference model predicts every output each cycle; directed
//            scenarios pin literal expectations, then a randomized phase
//            exercises mixed writes, pushes, timeouts and read throttling.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft601_mcfifo_pkt_buf;
    localparam int NC  = 2;
    localparam int DW  = 36;
    localparam int DP  = 128;
    localparam int TW  = 16;
    localparam int MPS = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [31:0]      max_packet_size;
    logic [TW-1:0]    flush_timeout;
    logic [NC*DW-1:0] wr_data;
    logic [NC-1:0]    wr_en, wr_push;
    logic [NC-1:0]    writeable, almost_unwriteable, overflow;
    logic             rd_en;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic [0:0]       rd_ch;
    logic [7:0]       rd_xfer_len;
    logic             rd_xfer_req, rd_xfer_almost_done, rd_xfer_done;
    logic             rd_gate, thr;

    assign rd_en = rd_gate && thr && rd_xfer_req && !rd_xfer_done;
    always #5 clk = ~clk;

    ft601_mcfifo_pkt_buf #(
        .NUM_CH(NC), .DATA_W(DW), .DEPTH(DP), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .max_packet_size(max_packet_size), .flush_timeout(flush_timeout),
        .wr_data(wr_data), .wr_en(wr_en), .wr_push(wr_push),
        .writeable(writeable), .almost_unwriteable(almost_unwriteable),
        .overflow(overflow), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_xfer_len(rd_xfer_len),
        .rd_xfer_req(rd_xfer_req), .rd_xfer_almost_done(rd_xfer_almost_done),
        .rd_xfer_done(rd_xfer_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // ------------------------------------------------------------------
    // Reference model: stored words as queues, counts as plain integers
    // ------------------------------------------------------------------
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    int m_unc[NC], m_cmt[NC], m_idle[NC];
    bit m_ovf[NC], m_wrbl[NC], m_aunw[NC];
    int m_mode, m_ch, m_len, m_rem, m_last;   // mode: 0 idle, 1 xfer, 2 done
    logic [DW-1:0] m_data;
    bit m_valid;

    function automatic int qsz(input int c);
        return (c == 0) ? mq0.size() : mq1.size();
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int c = 0; c < NC; c++) begin
            m_unc[c] = 0; m_cmt[c] = 0; m_idle[c] = 0;
            m_ovf[c] = 0; m_wrbl[c] = 0; m_aunw[c] = 0;
        end
        m_mode = 0; m_ch = 0; m_len = 0; m_rem = 0; m_last = NC - 1;
        m_data = '0; m_valid = 0;
    endtask

    task automatic model_step();
        int fr[NC];
        int gnt_c, gl, sum, amt, fn;
        bit st;
        for (int c = 0; c < NC; c++) fr[c] = DP - qsz(c);
        gnt_c = -1; gl = 0; m_valid = 0;
        if (m_mode == 0) begin
            for (int i = 1; i <= NC; i++) begin
                int k;
                k = (m_last + i) % NC;
                if (gnt_c < 0 && m_cmt[k] > 0) begin
                    gnt_c = k;
                    gl = (m_cmt[k] < MPS) ? m_cmt[k] : MPS;
                    m_ch = k; m_last = k; m_len = gl; m_rem = gl; m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (rd_en) begin
                if (m_ch == 0 && mq0.size() > 0) m_data = mq0.pop_front();
                else if (m_ch == 1 && mq1.size() > 0) m_data = mq1.pop_front();
                m_valid = 1;
                m_rem--;
                if (m_rem == 0) m_mode = 2;
            end
        end else begin
            m_mode = 0;
        end
        for (int c = 0; c < NC; c++) begin
            st = wr_en[c] && (fr[c] > 0);
            if (wr_en[c] && fr[c] == 0) m_ovf[c] = 1;
            if (st) begin
                if (c == 0) mq0.push_back(wr_data[0 +: DW]);
                else        mq1.push_back(wr_data[DW +: DW]);
            end
            sum = m_unc[c] + int'(st);
            if (sum >= MPS) amt = MPS;
            else if (wr_push[c] || (flush_timeout != 0 && m_unc[c] > 0 && m_idle[c] == int'(flush_timeout)))
                amt = sum;
            else amt = 0;
            if (st || amt > 0) m_idle[c] = 0;
            else if (m_unc[c] > 0 && m_idle[c] < 65535) m_idle[c]++;
            m_unc[c] = sum - amt;
            m_cmt[c] = m_cmt[c] + amt - ((gnt_c == c) ? gl : 0);
            fn = DP - qsz(c);
            m_wrbl[c] = (fn >= MPS);
            m_aunw[c] = (fn < 2 * MPS);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int c = 0; c < NC; c++) begin
                chk("writeable", 64'(writeable[c]), 64'(m_wrbl[c]));
                chk("almost_unwriteable", 64'(almost_unwriteable[c]), 64'(m_aunw[c]));
                chk("overflow", 64'(overflow[c]), 64'(m_ovf[c]));
            end
            chk("rd_xfer_req", 64'(rd_xfer_req), 64'(m_mode != 0));
            chk("rd_xfer_done", 64'(rd_xfer_done), 64'(m_mode == 2));
            chk("rd_xfer_almost_done", 64'(rd_xfer_almost_done), 64'(m_mode == 1 && m_rem == 1));
            chk("rd_valid", 64'(rd_valid), 64'(m_valid));
            if (m_valid) chk("rd_data", 64'(rd_data), 64'(m_data));
            if (m_mode != 0) begin
                chk("rd_ch", 64'(rd_ch), 64'(m_ch));
                chk("rd_xfer_len", 64'(rd_xfer_len), 64'(m_len));
            end
        end
    end

    // Event log for literal expectations
    int          g_ch[$], g_len[$], g_cyc[$];
    logic [31:0] rdq[$];
    int          done_cnt = 0, alm_cnt = 0;
    bit          req_prev = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_xfer_req && !req_prev) begin
                g_ch.push_back(int'(rd_ch));
                g_len.push_back(int'(rd_xfer_len));
                g_cyc.push_back(cyc);
            end
            if (rd_valid) rdq.push_back(rd_data[31:0]);
            if (rd_xfer_done) done_cnt++;
            if (rd_xfer_almost_done && rd_en) alm_cnt++;
        end
        req_prev = rd_xfer_req;
    end

    task automatic clear_log();
        g_ch.delete(); g_len.delete(); g_cyc.delete(); rdq.delete();
        done_cnt = 0; alm_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; wr_en = '0; wr_push = '0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
    endtask

    task automatic wr_words(input int c, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en[c] = 1'b1;
            wr_data[c*DW +: DW] = DW'(first + i);
            tick();
        end
        wr_en[c] = 1'b0;
    endtask

    task automatic chk_seq(input string nm, input int first, input int n);
        chk({nm, "_count"}, 64'(rdq.size()), 64'(n));
        if (rdq.size() == n)
            for (int k = 0; k < n; k++) chk(nm, 64'(rdq[k]), 64'(first + k));
    endtask

    int w_edge;

    initial begin
        reset_n = 1'b1; wr_en = '0; wr_push = '0; wr_data = '0;
        max_packet_size = 32'd64; flush_timeout = '0; rd_gate = 1'b1; thr = 1'b1;
        #2;
        do_reset();
        cmp_en = 1'b1;

        // Reset state, then first valid status one clock later
        chk("reset_writeable", 64'(writeable), 64'd0);
        chk("reset_req", 64'(rd_xfer_req), 64'd0);
        chk("reset_len", 64'(rd_xfer_len), 64'd0);
        chk("reset_data", 64'(rd_data), 64'd0);
        tick();
        chk("post_reset_writeable", 64'(writeable), 64'd3);
        chk("post_reset_almost", 64'(almost_unwriteable), 64'd0);

        // 1: one full packet
        clear_log();
        wr_words(0, 1, 16);
        repeat (40) tick();
        chk("s1_grants", 64'(g_ch.size()), 64'd1);
        if (g_ch.size() == 1) begin
            chk("s1_ch", 64'(g_ch[0]), 64'd0);
            chk("s1_len", 64'(g_len[0]), 64'd16);
        end
        chk("s1_model_len", 64'(m_len), 64'd16);
        chk_seq("s1_data", 1, 16);
        chk("s1_done_pulses", 64'(done_cnt), 64'd1);
        chk("s1_almost_pops", 64'(alm_cnt), 64'd1);

        // 2: two packets back to back
        clear_log();
        wr_words(0, 1, 32);
        repeat (60) tick();
        chk("s2_grants", 64'(g_ch.size()), 64'd2);
        if (g_len.size() == 2) begin
            chk("s2_len0", 64'(g_len[0]), 64'd16);
            chk("s2_len1", 64'(g_len[1]), 64'd16);
        end
        chk_seq("s2_data", 1, 32);

        // 3: explicit push of a partial packet, then an empty push
        clear_log();
        wr_words(0, 50, 8);
        wr_push[0] = 1'b1; tick(); wr_push[0] = 1'b0;
        repeat (40) tick();
        chk("s3_grants", 64'(g_ch.size()), 64'd1);
        if (g_len.size() == 1) chk("s3_len", 64'(g_len[0]), 64'd8);
        chk_seq("s3_data", 50, 8);
        clear_log();
        wr_push[0] = 1'b1; tick(); wr_push[0] = 1'b0;
        repeat (40) tick();
        chk("s3_empty_push_grants", 64'(g_ch.size()), 64'd0);

        // 4: idle timeout commit, then timeout disabled
        clear_log();
        flush_timeout = 16'd20;
        wr_words(1, 101, 5);
        w_edge = cyc;
        repeat (40) tick();
        chk("s4_grants", 64'(g_ch.size()), 64'd1);
        if (g_ch.size() == 1) begin
            chk("s4_ch", 64'(g_ch[0]), 64'd1);
            chk("s4_len", 64'(g_len[0]), 64'd5);
            chk("s4_latency_21_22", 64'((g_cyc[0] - w_edge >= 21) && (g_cyc[0] - w_edge <= 22)), 64'd1);
        end
        chk_seq("s4_data", 101, 5);
        clear_log();
        flush_timeout = '0;
        wr_words(1, 201, 5);
        repeat (1000) tick();
        chk("s4_no_timeout_grants", 64'(g_ch.size()), 64'd0);
        wr_push[1] = 1'b1; tick(); wr_push[1] = 1'b0;
        repeat (30) tick();

        // 5: simultaneous commits, round robin over two rounds
        clear_log();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) begin
                wr_en = 2'b11;
                wr_data = {DW'(300 + i), DW'(400 + i)};
                tick();
            end
            wr_en = '0;
            repeat (80) tick();
        end
        chk("s5_grants", 64'(g_ch.size()), 64'd4);
        if (g_ch.size() == 4) begin
            chk("s5_order0", 64'(g_ch[0]), 64'd0);
            chk("s5_order1", 64'(g_ch[1]), 64'd1);
            chk("s5_order2", 64'(g_ch[2]), 64'd0);
            chk("s5_order3", 64'(g_ch[3]), 64'd1);
        end

        // 6: fill with no reads, status thresholds, overflow, reset mid-transfer
        rd_gate = 1'b0;
        for (int k = 1; k <= 129; k++) begin
            wr_en[0] = 1'b1;
            wr_data[0 +: DW] = DW'(k);
            tick();
            if (k == 96)  chk("s6_almost_w96", 64'(almost_unwriteable[0]), 64'd0);
            if (k == 97)  chk("s6_almost_w97", 64'(almost_unwriteable[0]), 64'd1);
            if (k == 112) chk("s6_writeable_w112", 64'(writeable[0]), 64'd1);
            if (k == 113) chk("s6_writeable_w113", 64'(writeable[0]), 64'd0);
            if (k == 128) chk("s6_overflow_w128", 64'(overflow[0]), 64'd0);
        end
        wr_en = '0;
        chk("s6_overflow_w129", 64'(overflow[0]), 64'd1);
        chk("s6_req_stalled", 64'(rd_xfer_req), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("s6_rst_overflow", 64'(overflow), 64'd0);
        chk("s6_rst_req", 64'(rd_xfer_req), 64'd0);
        chk("s6_rst_len", 64'(rd_xfer_len), 64'd0);
        chk("s6_rst_status", 64'({writeable, almost_unwriteable}), 64'd0);
        rd_gate = 1'b1;
        do_reset();

        // Randomized phase
        flush_timeout = TW'($urandom_range(3, 40));
        for (int n = 0; n < 3000; n++) begin
            int wp, rp;
            wp = (n < 1000) ? 40 : (n < 2000) ? 75 : 20;
            rp = (n < 1000) ? 90 : (n < 2000) ? 10 : 70;
            for (int c = 0; c < NC; c++) begin
                wr_en[c]   = ($urandom_range(0, 99) < wp);
                wr_push[c] = ($urandom_range(0, 99) < 3);
                wr_data[c*DW +: DW] = {4'($urandom_range(0, 15)), 32'($urandom)};
            end
            thr = ($urandom_range(0, 99) < rp);
            tick();
        end
        wr_en = '0; wr_push = 2'b11; thr = 1'b1;
        tick();
        wr_push = '0;
        repeat (800) tick();
        chk("rand_drained_writeable", 64'(writeable), 64'd3);
        chk("rand_drained_almost", 64'(almost_unwriteable), 64'd0);
        chk("rand_drained_req", 64'(rd_xfer_req), 64'd0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ft601_mcfifo_pkt_buf.md
# ft601_mcfifo_pkt_buf

Multi-channel, single-clock packetising write buffer for the FT601 USB path. It accepts NUM_CH independent word streams and stores each in its own FIFO. It commits data into transfers of at most max_packet_size bytes, closing a transfer on a full packet, an explicit push or an idle timeout. A round-robin arbiter then hands one channel's transfer at a time to the downstream FT601 multi-channel FIFO master.

## Interface
- NUM_CH, 4: number of channels, 1..4.
- DATA_W, 36: word width (32 data + 4 byte-enable).
- DEPTH, 1024: words per channel FIFO, power of 2.
- TIMEOUT_W, 16: width of flush_timeout.
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- max_packet_size  in  32  bytes per packet. Multiple of 4, range 4..4*DEPTH. Bits [1:0] are ignored. MPS_W = max_packet_size>>2. Static while transfers are active.
- flush_timeout  in  TIMEOUT_W  idle cycles before a partial packet is committed. 0 disables the timeout.
- wr_data  in  NUM_CH*DATA_W  per-channel write word; channel c occupies bits [c*DATA_W +: DATA_W].
- wr_en  in  NUM_CH  per-channel write strobe.
- wr_push  in  NUM_CH  per-channel commit of a partial packet.
- writeable  out  NUM_CH  free space ≥ MPS_W.
- almost_unwriteable  out  NUM_CH  free space < 2*MPS_W.
- overflow  out  NUM_CH  sticky flag: a word was dropped because the FIFO was full.
- rd_en  in  1  pop one word of the granted transfer.
- rd_data  out  DATA_W  popped word.
- rd_valid  out  1  rd_data valid.
- rd_ch  out  $clog2(NUM_CH) (min 1)  channel of the current transfer.
- rd_xfer_len  out  $clog2(DEPTH)+1  words in the current transfer.
- rd_xfer_req  out  1  transfer granted and pending.
- rd_xfer_almost_done  out  1  exactly one word remains.
- rd_xfer_done  out  1  one-cycle end-of-transfer.

## Operation
- Each channel keeps the following state: a RAM of DEPTH words, wr_ptr and rd_ptr, free (DEPTH..0), uncommitted (words not yet in a transfer), committed (words available for a grant), and an idle counter.
- Write rules:
  - A word is stored when wr_en[c]=1 and free>0.
  - When wr_en[c]=1 and free=0, the word is dropped and overflow[c] is set.
- Commit occurs when any of these holds:
  - (a) uncommitted reaches MPS_W. Only MPS_W words are moved to committed.
  - (b) wr_push[c]=1 and uncommitted (including any word written in the same cycle) > 0. All uncommitted words are moved.
  - (c) flush_timeout≠0, uncommitted>0, and the idle counter equals flush_timeout. All uncommitted words are moved.
  - wr_push with nothing uncommitted is a no-op.
- Idle counter: cleared on every stored word and on every commit. Increments while uncommitted>0, saturating.
- Read FSM:
  - IDLE: scan channels round-robin, starting at the channel after the last grant (channel 0 after reset), for committed>0. On a hit, go to XFER and latch:
    - rd_ch;
    - len = min(committed, MPS_W) into rd_xfer_len;
    - remaining = len.
    - Also subtract len from committed.
  - XFER: rd_xfer_req=1. Each cycle with rd_en=1, read one word from rd_ch, advance rd_ptr, increment free and decrement remaining. When remaining goes 1→0, go to DONE.
  - DONE: rd_xfer_req=1 and rd_xfer_done=1 for exactly one cycle, then return to IDLE.
- rd_en outside XFER is ignored: no pop, rd_valid stays 0.
- Commit, grant and pop may hit the same channel in one cycle. All counters apply the net update.
- overflow clears only on reset.

## Timing
- Reset values (asynchronous): all pointers and counters 0, free=DEPTH, state IDLE, rd_ch=0, rd_xfer_len=0, rd_data=0, and every other output 0.
- writeable and almost_unwriteable are registered. They update the cycle after the causing write or pop; the first valid value appears one clock after reset release.
- Commit is registered, so committed reflects a write or push on the next edge.
- Grant latency: IDLE sees committed>0 on edge N, and rd_xfer_req rises at edge N+1.
- Read latency: rd_data and rd_valid follow the popping rd_en by 1 cycle (registered RAM read).
- rd_xfer_almost_done is high whenever remaining==1 in XFER.
- After the last pop:
  - rd_xfer_done=1 the next cycle;
  - rd_xfer_req=0 the cycle after;
  - the next grant comes no earlier than 1 IDLE cycle later.
- Upstream gating rd_en = rd_xfer_req && !rd_xfer_done is therefore exact and never over-pops.
- Reset asserted mid-transfer drops all buffered data immediately; the bench must not expect completion.

## Test plan
Configuration for all scenarios: NUM_CH=2, DEPTH=128, max_packet_size=64 (MPS_W=16), rd_en=rd_xfer_req&&!rd_xfer_done unless stated otherwise.
1. Ch0 writes 16 words 1..16 → one grant with rd_ch=0, rd_xfer_len=16. rd_data 1..16 arrives in order, almost_done is high during the 16th pop, and done pulses once.
2. Ch0 writes 32 words 1..32 → two transfers of len 16 (1..16, then 17..32), with req low for ≥1 cycle between them.
3. Ch0 writes 8 words, then wr_push alone the next cycle → one transfer with len 8. A second push with no data → no transfer.
4. Ch1 writes 5 words with flush_timeout=20 → grant 21–22 cycles after the last write, len 5. Repeating with flush_timeout=0 → no grant for 1000 cycles.
5. Both channels commit 16 words on the same edge → ch0 is granted first, then ch1. Next round, both commit again → ch0 first (round robin continues after ch1).
6. rd_en forced 0, ch0 writes 129 words:
   - writeable[0] falls after word 113;
   - almost_unwriteable[0] rises after word 97;
   - word 129 is dropped and overflow[0]=1.
   - Then reset_n pulses low mid-XFER → all outputs 0 at once and overflow is cleared.
